// File: rtl/pipelined_rca.sv
// -----------------------------------------------------------------------------
// pipelined_rca
//   Pipelined ripple-carry adder. Each stage resolves STAGE_BITS bits of the
//   sum through a chain of full_adder cells. The slice carry-out is registered
//   into the next stage. Sustains one addition per cycle. Latency is
//   WIDTH/STAGE_BITS cycles.
//
//   Parameters
//     WIDTH       operand / sum width (>= 2)
//     STAGE_BITS  bits per stage; WIDTH must be a multiple of it
//
//   Ports
//     clk        in   rising-edge clock
//     rst_n      in   synchronous active-low reset (clears every stage)
//     in_valid   in   operand beat present
//     in_ready   out  beat accepted this cycle (combinational from output side)
//     a, b       in   WIDTH-bit operands
//     cin        in   carry-in
//     out_valid  out  result beat present
//     out_ready  in   downstream consumes the result
//     sum        out  (a + b + cin) mod 2^WIDTH
//     cout       out  carry out of bit WIDTH-1
//     ovf        out  signed overflow (carry into MSB ^ carry out of MSB)
// -----------------------------------------------------------------------------

// One-bit full adder cell used for every bit slice of the pipeline.
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_ci,
    output logic o_s,
    output logic o_co
);
    assign o_s  = i_a ^ i_b ^ i_ci;
    assign o_co = (i_a & i_b) | (i_ci & (i_a ^ i_b));
endmodule

module pipelined_rca #(
    parameter int WIDTH      = 8,
    parameter int STAGE_BITS = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int SB     = STAGE_BITS;
    localparam int STAGES = WIDTH / STAGE_BITS;

    // The whole pipeline moves as one: it advances whenever the output slot is
    // empty or being consumed, otherwise every stage freezes.
    logic w_adv;
    assign w_adv    = !out_valid || out_ready;
    assign in_ready = w_adv;

    for (genvar s = 0; s < STAGES; s++) begin : g_st
        // Operand bits still to be added when entering stage s. Forwarded
        // operands are stored already shifted down, so the slice for this
        // stage always sits at [SB-1:0].
        localparam int REM = WIDTH - s * SB;

        logic [REM-1:0]        w_src_a;
        logic [REM-1:0]        w_src_b;
        logic                  w_src_vld;
        logic [SB:0]           w_c;
        logic [SB-1:0]         w_s;
        logic [(s+1)*SB-1:0]   w_sum_nxt;

        logic                  r_vld;
        logic                  r_c;
        logic [(s+1)*SB-1:0]   r_sum;

        if (s == 0) begin : g_head
            assign w_src_a   = a;
            assign w_src_b   = b;
            assign w_src_vld = in_valid;
            assign w_c[0]    = cin;
            assign w_sum_nxt = w_s;
        end else begin : g_body
            assign w_src_a   = g_st[s-1].g_fwd.r_a;
            assign w_src_b   = g_st[s-1].g_fwd.r_b;
            assign w_src_vld = g_st[s-1].r_vld;
            assign w_c[0]    = g_st[s-1].r_c;
            // New slice lands directly above the bits resolved so far.
            assign w_sum_nxt = {w_s, g_st[s-1].r_sum};
        end

        for (genvar i = 0; i < SB; i++) begin : g_fa
            full_adder u_fa (
                .i_a  (w_src_a[i]),
                .i_b  (w_src_b[i]),
                .i_ci (w_c[i]),
                .o_s  (w_s[i]),
                .o_co (w_c[i+1])
            );
        end

        // Stage valid, carry and accumulated sum; data only loads on a valid
        // beat so bubbles leave the previous result in place.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_vld <= 1'b0;
                r_c   <= 1'b0;
                r_sum <= {((s+1)*SB){1'b0}};
            end else if (w_adv) begin
                r_vld <= w_src_vld;
                if (w_src_vld) begin
                    r_c   <= w_c[SB];
                    r_sum <= w_sum_nxt;
                end
            end
        end

        if (s < STAGES - 1) begin : g_fwd
            logic [REM-SB-1:0] r_a;
            logic [REM-SB-1:0] r_b;

            // Forward the not-yet-added operand bits, shifted to the bottom.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_a <= {(REM-SB){1'b0}};
                    r_b <= {(REM-SB){1'b0}};
                end else if (w_adv && w_src_vld) begin
                    r_a <= w_src_a[REM-1:SB];
                    r_b <= w_src_b[REM-1:SB];
                end
            end
        end else begin : g_last
            logic r_ovf;

            // Signed overflow: carry into the top full adder XOR its carry-out.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_src_vld) begin
                    r_ovf <= w_c[SB] ^ w_c[SB-1];
                end
            end
        end
    end

    assign out_valid = g_st[STAGES-1].r_vld;
    assign sum       = g_st[STAGES-1].r_sum;
    assign cout      = g_st[STAGES-1].r_c;
    assign ovf       = g_st[STAGES-1].g_last.r_ovf;

endmodule

// File: tb/tb_pipelined_rca.sv
// -----------------------------------------------------------------------------
// tb_pipelined_rca
//   Self-checking bench for pipelined_rca (WIDTH=8, STAGE_BITS=2).
//   A reference model holds one slot per pipeline cycle of latency, filled from
//   plain integer arithmetic, and shifts whenever the output slot is empty or
//   consumed. Outputs are compared against it every cycle, and a few directed
//   cases are additionally pinned against hand-computed literals.
// -----------------------------------------------------------------------------
module tb_pipelined_rca;
    localparam int W  = 8;
    localparam int SB = 2;
    localparam int ST = W / SB;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;

    always #5 clk = ~clk;

    pipelined_rca #(.WIDTH(W), .STAGE_BITS(SB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    int n_vec  = 0;
    int n_fail = 0;
    int n_cmp  = 0;

    // Model: one slot per cycle of latency; slot ST-1 is what the outputs show.
    logic       m_v [ST];
    logic [8:0] m_s [ST];
    logic       m_o [ST];

    function automatic void cmp(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_clear();
        for (int i = 0; i < ST; i++) begin
            m_v[i] = 1'b0;
            m_s[i] = 9'd0;
            m_o[i] = 1'b0;
        end
    endtask

    // One clock cycle: check outputs, drive inputs, update model, take the edge.
    task automatic tick(input logic rst, input logic v, input logic [7:0] x,
                        input logic [7:0] y, input logic c, input logic ordy);
        logic [8:0] usum;
        int         sx;
        int         sy;
        int         ssum;
        @(negedge clk);
        cmp("out_valid", 32'(out_valid), 32'(m_v[ST-1]));
        if (m_v[ST-1]) begin
            cmp("sum",  32'(sum),  32'(m_s[ST-1][7:0]));
            cmp("cout", 32'(cout), 32'(m_s[ST-1][8]));
            cmp("ovf",  32'(ovf),  32'(m_o[ST-1]));
        end
        rst_n     = rst;
        in_valid  = v;
        a         = x;
        b         = y;
        cin       = c;
        out_ready = ordy;
        #1;
        cmp("in_ready", 32'(in_ready), 32'(!m_v[ST-1] || ordy));
        if (!rst) begin
            model_clear();
        end else if (!m_v[ST-1] || ordy) begin
            for (int i = ST - 1; i > 0; i--) begin
                m_v[i] = m_v[i-1];
                m_s[i] = m_s[i-1];
                m_o[i] = m_o[i-1];
            end
            usum = {1'b0, x} + {1'b0, y} + {8'd0, c};
            sx   = int'($signed(x));
            sy   = int'($signed(y));
            ssum = sx + sy + (c ? 1 : 0);
            m_v[0] = v;
            m_s[0] = usum;
            m_o[0] = (ssum > 127) || (ssum < -128);
            if (v) n_vec++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < ST + 1; i++) tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    endtask

    // Single isolated beat with latency and literal result checks.
    task automatic single(input logic [7:0] x, input logic [7:0] y, input logic c,
                          input logic [7:0] es, input logic ec, input logic eo,
                          input string nm);
        int n;
        drain();
        tick(1'b1, 1'b1, x, y, c, 1'b1);
        n = 1;
        while (!out_valid && n < 20) begin
            tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            n++;
        end
        cmp({nm, "_latency"}, 32'(n), 32'(ST));
        cmp({nm, "_sum"},  32'(sum),  32'(es));
        cmp({nm, "_cout"}, 32'(cout), 32'(ec));
        cmp({nm, "_ovf"},  32'(ovf),  32'(eo));
    endtask

    initial begin
        logic [31:0] r1;
        logic [31:0] r2;
        logic [7:0]  held;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        cin       = 1'b0;
        out_ready = 1'b1;
        model_clear();
        repeat (2) @(posedge clk);
        #1;

        // Reset values
        tick(1'b0, 1'b1, 8'h12, 8'h34, 1'b1, 1'b0);
        cmp("rst_out_valid", 32'(out_valid), 32'd0);
        cmp("rst_sum",       32'(sum),       32'd0);
        cmp("rst_cout",      32'(cout),      32'd0);
        cmp("rst_ovf",       32'(ovf),       32'd0);
        cmp("rst_in_ready",  32'(in_ready),  32'd1);

        // Directed literal cases
        single(8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0, "basic");
        single(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "ripple_ff");
        single(8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0, "ripple_aa");
        single(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, "ovf_pos");
        single(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, "ovf_neg");

        // Streaming: 16 back-to-back random beats
        drain();
        for (int k = 0; k < 16; k++) begin
            r1 = $urandom();
            r2 = $urandom();
            tick(1'b1, 1'b1, r1[7:0], r2[7:0], r1[8], 1'b1);
        end
        drain();

        // Backpressure: output stalled for 3 cycles while results are present
        held = 8'h00;
        for (int k = 0; k < 10; k++) begin
            r1 = $urandom();
            r2 = $urandom();
            tick(1'b1, 1'b1, r1[7:0], r2[7:0], r1[8], !(k >= 5 && k < 8));
            if (k == 5) held = sum;
            if (k == 6 || k == 7) begin
                cmp("bp_sum_held", 32'(sum),      32'(held));
                cmp("bp_in_ready", 32'(in_ready), 32'd0);
            end
        end
        drain();

        // Reset with three beats in flight; none may emerge afterwards
        tick(1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 8'h03, 8'h04, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 8'h05, 8'h06, 1'b0, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
        cmp("midrst_out_valid", 32'(out_valid), 32'd0);
        for (int k = 0; k < ST + 2; k++) begin
            tick(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
            cmp("midrst_no_ghost", 32'(out_valid), 32'd0);
        end
        single(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, "after_rst");

        // Random valid / backpressure mix
        for (int k = 0; k < 400; k++) begin
            r1 = $urandom();
            r2 = $urandom();
            tick(1'b1, r1[9] | r1[10], r1[7:0], r2[7:0], r1[8], r2[9] | r2[10]);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
